// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmit serializer with send/ready handshake
// Optional front-end FIFO: define UART_TX_FIFO_EN (depth FIFO_DEPTH).
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 out
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $fatal(1, "uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 tick;
    logic                 load_en;
    logic [DATA_BITS-1:0] load_word;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
        $fatal(1, "uart_tx_frame: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 push, pop;

    assign ready     = (count_q != (PTR_W + 1)'(FIFO_DEPTH));
    assign push      = send && ready;
    // The FSM drains the FIFO only from IDLE, so START follows the pop by one cycle.
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign load_en   = pop;
    assign load_word = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign busy_d = (state_d != S_IDLE) || (count_d != '0);
`else
    assign ready     = (state_q == S_IDLE);
    assign load_en   = send && ready;
    assign load_word = data;
    assign busy_d    = (state_d != S_IDLE);
`endif

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    state_d = S_START;
                    shift_d = load_word;
                    par_d   = (PARITY == 1) ? ~^load_word : ^load_word;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the next state so out changes together with state_q.
        case (state_d)
            S_START: out_d = 1'b0;
            S_DATA:  out_d = shift_d[0];
            S_PAR:   out_d = par_d;
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
// Honours UART_TX_FIFO_EN when it is defined for the build.
module tb_uart_tx_frame;

`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] send_v = '0;
    logic [7:0] data_v [4];
    logic [3:0] ready_v, busy_v, out_v;

    int checks = 0;
    int passed = 0;

    logic cap_out   [512];
    logic cap_busy  [512];
    logic cap_ready [512];

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2; all at 4 clk per bit
    uart_tx_frame #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .send(send_v[0]), .data(data_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .out(out_v[0]));
    uart_tx_frame #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8)) u_e (
        .clk(clk), .rst_n(rst_n), .send(send_v[1]), .data(data_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .out(out_v[1]));
    uart_tx_frame #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u_o (
        .clk(clk), .rst_n(rst_n), .send(send_v[2]), .data(data_v[2]),
        .ready(ready_v[2]), .busy(busy_v[2]), .out(out_v[2]));
    uart_tx_frame #(.DATA_BITS(5), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8)) u_s (
        .clk(clk), .rst_n(rst_n), .send(send_v[3]), .data(data_v[3][4:0]),
        .ready(ready_v[3]), .busy(busy_v[3]), .out(out_v[3]));

    function automatic logic [15:0] period_bits(input int start, input int nper);
        logic [15:0] v = '0;
        for (int j = 0; j < nper; j++) v[j] = cap_out[start + 4 * j];
        return v;
    endfunction

    function automatic int unstable_periods(input int start, input int nper);
        int n = 0;
        for (int j = 0; j < nper; j++)
            for (int k = 1; k < 4; k++)
                if (cap_out[start + 4 * j + k] !== cap_out[start + 4 * j]) n++;
        return n;
    endfunction

    function automatic int run_len_busy();
        int n = 0;
        while (n < 511 && cap_busy[n] === 1'b1) n++;
        return n;
    endfunction

    task automatic send_word(input int idx, input logic [7:0] d);
        @(negedge clk);
        send_v[idx] = 1'b1;
        data_v[idx] = d;
        @(posedge clk);
        #1;
        send_v[idx] = 1'b0;
    endtask

    task automatic capture(input int idx, input int n, input int hold_from, input int hold_to,
                           input logic [7:0] hold_data);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap_out[c]   = out_v[idx];
            cap_busy[c]  = busy_v[idx];
            cap_ready[c] = ready_v[idx];
            if (c == hold_from) begin
                send_v[idx] = 1'b1;
                data_v[idx] = hold_data;
            end
            if (c == hold_to) send_v[idx] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int idx);
        int n = 0;
        while (busy_v[idx] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) $display("FAIL wait_idle[%0d]: busy=%b still high after %0d cycles, required 0", idx, busy_v[idx], n);
        else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_v !== 4'hF) $display("FAIL reset_out: got %b required 1111", out_v);
        else passed++;
        checks++;
        if (busy_v !== 4'h0) $display("FAIL reset_busy: got %b required 0000", busy_v);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_v !== 4'hF) $display("FAIL reset_ready: got %b required 1111", ready_v);
        else passed++;
    endtask

    task automatic test_basic_frame();
        int low_run;
        send_word(0, 8'hA5);
        capture(0, 50, -1, -1, 8'h00);
        checks++;
        if (period_bits(LAT, 10) !== 16'({1'b1, 8'hA5, 1'b0}))
            $display("FAIL a5_bits: got %b required %b", period_bits(LAT, 10), 16'({1'b1, 8'hA5, 1'b0}));
        else passed++;
        checks++;
        if (unstable_periods(LAT, 10) != 0) $display("FAIL a5_hold: %0d unstable samples, required 0", unstable_periods(LAT, 10));
        else passed++;
        checks++;
        if (run_len_busy() != 40 + LAT) $display("FAIL a5_busy_len: got %0d required %0d", run_len_busy(), 40 + LAT);
        else passed++;
        checks++;
        if (cap_out[40 + LAT] !== 1'b1) $display("FAIL a5_idle_after: got %b required 1", cap_out[40 + LAT]);
        else passed++;
`ifndef UART_TX_FIFO_EN
        low_run = 0;
        while (low_run < 49 && cap_ready[low_run] === 1'b0) low_run++;
        checks++;
        if (low_run != 40 || cap_ready[40] !== 1'b1)
            $display("FAIL a5_ready_len: low for %0d cycles (then %b), required 40 (then 1)", low_run, cap_ready[40]);
        else passed++;
`endif
    endtask

    task automatic test_parity();
        send_word(1, 8'h07);
        capture(1, 50, -1, -1, 8'h00);
        checks++;
        if (period_bits(LAT, 11) !== 16'({1'b1, 1'b1, 8'h07, 1'b0}))
            $display("FAIL even_07: got %b required %b", period_bits(LAT, 11), 16'({1'b1, 1'b1, 8'h07, 1'b0}));
        else passed++;
        checks++;
        if (run_len_busy() != 44 + LAT) $display("FAIL even_len: got %0d required %0d", run_len_busy(), 44 + LAT);
        else passed++;
        send_word(2, 8'h07);
        capture(2, 50, -1, -1, 8'h00);
        checks++;
        if (period_bits(LAT, 11) !== 16'({1'b1, 1'b0, 8'h07, 1'b0}))
            $display("FAIL odd_07: got %b required %b", period_bits(LAT, 11), 16'({1'b1, 1'b0, 8'h07, 1'b0}));
        else passed++;
        send_word(2, 8'h00);
        capture(2, 50, -1, -1, 8'h00);
        checks++;
        if (period_bits(LAT, 11) !== 16'({1'b1, 1'b1, 8'h00, 1'b0}))
            $display("FAIL odd_00: got %b required %b", period_bits(LAT, 11), 16'({1'b1, 1'b1, 8'h00, 1'b0}));
        else passed++;
        checks++;
        if (unstable_periods(LAT, 11) != 0) $display("FAIL odd_hold: %0d unstable samples, required 0", unstable_periods(LAT, 11));
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ones;
        @(negedge clk);
        send_v[3] = 1'b1;
        data_v[3] = 8'h1F;
        @(posedge clk);
        #1;
        data_v[3] = 8'h00;
        capture(3, 70, -1, 40, 8'h00);
        checks++;
        if (period_bits(LAT, 8) !== 16'h00FE) $display("FAIL b2b_first: got %h required 00fe", period_bits(LAT, 8));
        else passed++;
        ones = 0;
        while (ones < 60 && cap_out[LAT + 4 + ones] === 1'b1) ones++;
        checks++;
        if (ones != 29) $display("FAIL b2b_stop_gap: high for %0d cycles, required 29", ones);
        else passed++;
        checks++;
        if (period_bits(33 + LAT, 8) !== 16'h00C0) $display("FAIL b2b_second: got %h required 00c0", period_bits(33 + LAT, 8));
        else passed++;
        checks++;
        if (unstable_periods(33 + LAT, 8) != 0) $display("FAIL b2b_hold: %0d unstable samples, required 0", unstable_periods(33 + LAT, 8));
        else passed++;
        wait_idle(3);
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_send_while_busy();
        int bad_out = 0;
        int bad_busy = 0;
        send_word(0, 8'h96);
        capture(0, 60, 2, 30, 8'h3C);
        checks++;
        if (period_bits(0, 10) !== 16'({1'b1, 8'h96, 1'b0}))
            $display("FAIL busy_send_frame: got %b required %b", period_bits(0, 10), 16'({1'b1, 8'h96, 1'b0}));
        else passed++;
        for (int c = 40; c < 60; c++) begin
            if (cap_out[c] !== 1'b1) bad_out++;
            if (cap_busy[c] !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_out != 0) $display("FAIL busy_send_idle_out: %0d non-idle samples, required 0", bad_out);
        else passed++;
        checks++;
        if (bad_busy != 0) $display("FAIL busy_send_idle_busy: %0d busy samples, required 0", bad_busy);
        else passed++;
    endtask
`endif

    task automatic test_reset_mid_frame();
        send_word(0, 8'hFF);
        repeat (14) @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1) $display("FAIL rst_pre_busy: got %b required 1", busy_v[0]);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0)
            $display("FAIL rst_mid_data: out=%b busy=%b required out=1 busy=0", out_v[0], busy_v[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        send_word(0, 8'h00);
        repeat (LAT + 1) @(negedge clk);
        checks++;
        if (out_v[0] !== 1'b0) $display("FAIL rst_pre_start: got %b required 0", out_v[0]);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_v[0] !== 1'b1) $display("FAIL rst_mid_start: got %b required 1", out_v[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0)
            $display("FAIL rst_release: ready=%b busy=%b required ready=1 busy=0", ready_v[0], busy_v[0]);
        else passed++;
        send_word(0, 8'h55);
        capture(0, 50, -1, -1, 8'h00);
        checks++;
        if (period_bits(LAT, 10) !== 16'({1'b1, 8'h55, 1'b0}))
            $display("FAIL rst_next_55: got %b required %b", period_bits(LAT, 10), 16'({1'b1, 8'h55, 1'b0}));
        else passed++;
        checks++;
        if (unstable_periods(LAT, 10) != 0) $display("FAIL rst_next_hold: %0d unstable samples, required 0", unstable_periods(LAT, 10));
        else passed++;
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo();
        int  nxt = 1;
        int  acc9_c = -1;
        int  bad_frames = 0;
        int  bad_busy = 0;
        logic acc;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            cap_out[c]   = out_v[0];
            cap_busy[c]  = busy_v[0];
            cap_ready[c] = ready_v[0];
            if (nxt <= 9) begin
                send_v[0] = 1'b1;
                data_v[0] = 8'(nxt);
                acc = ready_v[0];
            end else begin
                send_v[0] = 1'b0;
                acc = 1'b0;
            end
            if (acc) begin
                if (nxt == 9) acc9_c = c;
                nxt++;
            end
        end
        send_v[0] = 1'b0;
        checks++;
        if (nxt != 10) $display("FAIL fifo_accepts: accepted %0d words, required 9", nxt - 1);
        else passed++;
        checks++;
        if (acc9_c < 0 || cap_ready[acc9_c + 1] !== 1'b0)
            $display("FAIL fifo_full_ready: ninth accept cycle %0d, ready after %b, required 0", acc9_c, cap_ready[acc9_c + 1]);
        else passed++;
        for (int k = 0; k < 9; k++) begin
            if (period_bits(2 + 41 * k, 10) !== 16'({1'b1, 8'(k + 1), 1'b0})) bad_frames++;
            if (unstable_periods(2 + 41 * k, 10) != 0) bad_frames++;
            if (k < 8 && cap_out[2 + 41 * k + 40] !== 1'b1) bad_frames++;
        end
        checks++;
        if (bad_frames != 0) $display("FAIL fifo_order: %0d frame errors, required 0", bad_frames);
        else passed++;
        for (int c = 1; c < 370; c++) if (cap_busy[c] !== 1'b1) bad_busy++;
        checks++;
        if (bad_busy != 0 || cap_busy[370] !== 1'b0)
            $display("FAIL fifo_busy: %0d low samples, end=%b, required 0 low and end=0", bad_busy, cap_busy[370]);
        else passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
`ifndef UART_TX_FIFO_EN
        test_send_while_busy();
`endif
        test_reset_mid_frame();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
